uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a receive FIFO, with a
// two-register bus slave for reading data and control/status.
//
// Ports
//   clk_clk      single system clock
//   reset_reset  synchronous, active-high reset
//   uart_rxd     asynchronous serial input, idle high
//   address      register select: 0 = data, 1 = control/status
//   chipselect   bus access qualifier
//   read, write  bus strobes
//   writedata    32-bit write data
//   readdata     32-bit registered read data (latency 1, held until next read)
//   irq          level interrupt: RE & FIFO not empty (registered)
//
// Receiver FSM
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | half a bit into the start bit, confirming it is still low
//   S_DATA   | sampling payload bits, LSB first, one per bit period
//   S_PARITY | sampling the parity bit (only when PARITY != 0)
//   S_STOP   | sampling the stop bit; push the frame if it is good
//   S_BREAK  | stop bit was low; wait for the line to return high
//
// Data register read:    [DATA_BITS-1:0] head, [15] RVALID, [31:16] count
// Control/status read:   [0] RE, [8] RI, [9] PE, [10] FE, [11] OV, [31:16] count
// Control write:         [0] loads RE, [9]/[10]/[11] clear PE/FE/OV

module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        uart_rxd,
    input  logic        address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    // Rounded clocks per sample tick, never below 1.
    localparam int TICK_RATE = BAUD * OVERSAMPLE;
    localparam int DIV_RAW   = (CLK_HZ + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W      = $clog2(OVERSAMPLE);
    localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;
    logic line_fall;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign line_fall = rxd_prev & ~rxd_sync;

    // ------------------------------------------------------------------
    // Timers: free-running tick divider, per-bit tick counter, bit counter
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_bad;
    logic                 push_req;
    logic [DATA_BITS-1:0] push_data;
    logic                 tick;
    logic                 sample_now;
    logic                 par_expect;

    assign tick       = (div_cnt == '0);
    assign sample_now = tick && (tick_cnt == '0);
    // Parity bit value that makes the frame valid for the selected mode.
    assign par_expect = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);

    // FSM controls
    logic start_det;
    logic load_full;
    logic shift_en;
    logic bits_load;
    logic pe_set;
    logic fe_set;
    logic stop_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (line_fall) state_nxt = S_START;
            end
            S_START: begin
                if (sample_now) state_nxt = rxd_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample_now && (bit_cnt == '0))
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (sample_now) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (sample_now) state_nxt = rxd_sync ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rxd_sync) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        start_det = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        bits_load = 1'b0;
        pe_set    = 1'b0;
        fe_set    = 1'b0;
        stop_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                start_det = line_fall;
            end
            S_START: begin
                load_full = sample_now;
                bits_load = sample_now;
            end
            S_DATA: begin
                load_full = sample_now;
                shift_en  = sample_now;
            end
            S_PARITY: begin
                load_full = sample_now;
                pe_set    = sample_now && (rxd_sync != par_expect);
            end
            S_STOP: begin
                // A parity-failed frame still runs through STOP so framing
                // is checked and the receiver stays bit-aligned.
                stop_ok = sample_now && rxd_sync && !frame_bad;
                fe_set  = sample_now && !rxd_sync;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_bad <= 1'b0;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            // Restarting on the start edge centres every later sample
            // in its bit cell.
            if (start_det || tick) begin
                div_cnt <= DIV_LAST;
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end

            if (start_det) begin
                tick_cnt <= HALF_LAST;
            end else if (load_full) begin
                tick_cnt <= FULL_LAST;
            end else if (tick && (tick_cnt != '0)) begin
                tick_cnt <= tick_cnt - 1'b1;
            end

            if (bits_load) begin
                bit_cnt <= BITS_LAST;
            end else if (shift_en && (bit_cnt != '0)) begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            if (shift_en) begin
                shift_reg <= {rxd_sync, shift_reg[DATA_BITS-1:1]};
            end

            if (start_det) begin
                frame_bad <= 1'b0;
            end else if (pe_set) begin
                frame_bad <= 1'b1;
            end

            push_req <= stop_ok;
            if (stop_ok) begin
                push_data <= shift_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus decode and FIFO
    // ------------------------------------------------------------------
    logic                 rd_data;
    logic                 rd_ctrl;
    logic                 wr_ctrl;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;
    logic                 ov_set;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    assign rd_data    = chipselect & read & ~address;
    assign rd_ctrl    = chipselect & read & address;
    assign wr_ctrl    = chipselect & write & address;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign pop        = rd_data & ~fifo_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign ov_set     = push_req & fifo_full & ~pop;

    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control / sticky status
    // ------------------------------------------------------------------
    logic re;
    logic pe;
    logic fe;
    logic ov;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            re <= 1'b0;
            pe <= 1'b0;
            fe <= 1'b0;
            ov <= 1'b0;
        end else begin
            if (wr_ctrl) re <= writedata[0];
            // Set beats clear when both happen in one cycle.
            pe <= (pe & ~(wr_ctrl & writedata[9]))  | pe_set;
            fe <= (fe & ~(wr_ctrl & writedata[10])) | fe_set;
            ov <= (ov & ~(wr_ctrl & writedata[11])) | ov_set;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:12], writedata[8:1]};

    // ------------------------------------------------------------------
    // Read response and interrupt
    // ------------------------------------------------------------------
    logic [31:0] data_word;
    logic [31:0] status_word;

    always_comb begin
        data_word                  = '0;
        data_word[DATA_BITS-1:0]   = mem[rd_ptr];
        data_word[15]              = 1'b1;
        data_word[31:16]           = 16'(count);

        status_word                = '0;
        status_word[0]             = re;
        status_word[8]             = ~fifo_empty;
        status_word[9]             = pe;
        status_word[10]            = fe;
        status_word[11]            = ov;
        status_word[31:16]         = 16'(count);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_data) begin
                readdata <= fifo_empty ? 32'd0 : data_word;
            end else if (rd_ctrl) begin
                readdata <= status_word;
            end
            irq <= re & ~fifo_empty;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: exercises two receiver instances (8N1 with a 4-entry
// FIFO, and 8E1 with an 8-entry FIFO) against a frame-level reference
// model built from queues and sticky flag bits.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int CLK_HZ  = 3686400;
    localparam int BAUD    = 115200;
    localparam int OS      = 16;
    localparam int BIT_CYC = 32;          // CLK_HZ / BAUD clocks per bit

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd0;
    logic        rxd1;
    logic        address;
    logic        cs0;
    logic        cs1;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        irq0;
    logic        irq1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic       m_re [2];
    logic       m_pe [2];
    logic       m_fe [2];
    logic       m_ov [2];
    int         depth [2] = '{4, 8};

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
    ) u_dut (
        .clk_clk(clk), .reset_reset(rst), .uart_rxd(rxd0),
        .address(address), .chipselect(cs0), .read(read), .write(write),
        .writedata(writedata), .readdata(rdata0), .irq(irq0)
    );

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(8)
    ) u_dut_p (
        .clk_clk(clk), .reset_reset(rst), .uart_rxd(rxd1),
        .address(address), .chipselect(cs1), .read(read), .write(write),
        .writedata(writedata), .readdata(rdata1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rxd(input int idx, input logic v);
        if (idx == 0) rxd0 = v;
        else          rxd1 = v;
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [31:0] model_status(input int idx);
        int n = qsize(idx);
        return {16'(n), 4'b0, m_ov[idx], m_fe[idx], m_pe[idx], (n != 0), 7'b0, m_re[idx]};
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int i = 0; i < 2; i++) begin
            m_re[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
        end
    endtask

    task automatic model_frame(input int idx, input logic [7:0] data,
                               input bit par_bad, input bit stop_bad);
        bit pbad = (idx == 1) && par_bad;
        if (pbad)     m_pe[idx] = 1;
        if (stop_bad) m_fe[idx] = 1;
        if (!pbad && !stop_bad) begin
            if (qsize(idx) == depth[idx]) m_ov[idx] = 1;
            else if (idx == 0) mq0.push_back(data);
            else mq1.push_back(data);
        end
    endtask

    // Start bit, payload and (instance 1 only) even parity bit.
    task automatic send_head(input int idx, input logic [7:0] data, input bit par_bad);
        set_rxd(idx, 1'b0);
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            set_rxd(idx, data[i]);
            idle(BIT_CYC);
        end
        if (idx == 1) begin
            set_rxd(idx, (^data) ^ par_bad);
            idle(BIT_CYC);
        end
    endtask

    task automatic send_frame(input int idx, input logic [7:0] data,
                              input bit par_bad, input bit stop_bad);
        send_head(idx, data, par_bad);
        set_rxd(idx, ~stop_bad);
        idle(BIT_CYC);
        if (stop_bad) begin
            set_rxd(idx, 1'b1);
            idle(BIT_CYC);
        end
        model_frame(idx, data, par_bad, stop_bad);
        idle($urandom_range(2, 10));
    endtask

    task automatic bus_read(input int idx, input logic addr, output logic [31:0] data);
        address = addr;
        cs0 = (idx == 0);
        cs1 = (idx == 1);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        cs0 = 1'b0;
        cs1 = 1'b0;
        data = (idx == 0) ? rdata0 : rdata1;
    endtask

    task automatic bus_write(input int idx, input logic addr, input logic [31:0] wd);
        address = addr;
        writedata = wd;
        cs0 = (idx == 0);
        cs1 = (idx == 1);
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        cs0 = 1'b0;
        cs1 = 1'b0;
        if (addr) begin
            m_re[idx] = wd[0];
            if (wd[9])  m_pe[idx] = 0;
            if (wd[10]) m_fe[idx] = 0;
            if (wd[11]) m_ov[idx] = 0;
        end
    endtask

    task automatic check_status(input int idx, input string tag);
        logic [31:0] got;
        bus_read(idx, 1'b1, got);
        check(tag, got, model_status(idx));
    endtask

    task automatic check_data(input int idx, input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  b;
        int n = qsize(idx);
        if (n == 0) begin
            exp = 32'd0;
        end else begin
            b = (idx == 0) ? mq0.pop_front() : mq1.pop_front();
            exp = {16'(n), 1'b1, 7'b0, b};
        end
        bus_read(idx, 1'b0, got);
        check(tag, got, exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [7:0]  b;

        rst = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1;
        address = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0;
        model_reset();
        idle(5);
        rst = 1'b0;
        idle(3);

        // Reset state
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_irq0", {31'd0, irq0}, 32'd0);
        check_status(0, "reset_status0");
        check_status(1, "reset_status1");

        // 0xA5 on 8N1, then a read of the empty FIFO
        send_frame(0, 8'hA5, 0, 0);
        bus_read(0, 1'b0, got);
        check("a5_literal", got, 32'h0001_80A5);
        void'(mq0.pop_front());
        idle(20);
        check("rdata_hold", rdata0, 32'h0001_80A5);
        check_data(0, "empty_read");

        // Framing error, recovery with 0x55, clear FE
        send_frame(0, 8'h00, 0, 1);
        check_status(0, "fe_status");
        send_frame(0, 8'h55, 0, 0);
        check_data(0, "after_fe_55");
        bus_write(0, 1'b1, 32'h400);
        check_status(0, "fe_cleared");

        // Overflow on the 4-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(0, 8'($urandom), 0, 0);
        check_status(0, "ov_status");
        for (int i = 0; i < 5; i++) check_data(0, $sformatf("ov_read%0d", i));
        bus_write(0, 1'b1, 32'h800);
        check_status(0, "ov_cleared");

        // Writes to the data address are ignored
        bus_write(0, 1'b0, 32'hFFFF_FFFF);
        check_status(0, "data_write_ignored");

        // Interrupt rises after the push and drops after the read
        bus_write(0, 1'b1, 32'h1);
        b = 8'($urandom);
        send_head(0, b, 0);
        set_rxd(0, 1'b1);
        idle(16);
        check("irq_before_push", {31'd0, irq0}, 32'd0);
        idle(6);
        check("irq_after_push", {31'd0, irq0}, 32'd1);
        idle(BIT_CYC - 22 + 4);
        model_frame(0, b, 0, 0);
        check_data(0, "irq_byte");
        @(negedge clk);
        check("irq_after_pop", {31'd0, irq0}, 32'd0);
        bus_write(0, 1'b1, 32'h0);

        // Quarter-bit glitch is a false start
        rxd0 = 1'b0;
        idle(BIT_CYC / 4);
        rxd0 = 1'b1;
        idle(3 * BIT_CYC);
        check_status(0, "glitch_status");

        // Even parity: bad parity on 0x3C, then clear PE
        send_frame(1, 8'h3C, 1, 0);
        check_status(1, "pe_status");
        bus_write(1, 1'b1, 32'h200);
        check_status(1, "pe_cleared");

        // Randomized frames on the parity instance
        for (int it = 0; it < 40; it++) begin
            bit pb = ($urandom_range(0, 3) == 0);
            bit sb = ($urandom_range(0, 7) == 0);
            send_frame(1, 8'($urandom), pb, sb);
            case ($urandom_range(0, 3))
                0: check_data(1, $sformatf("rnd_data%0d", it));
                1: check_status(1, $sformatf("rnd_status%0d", it));
                2: begin
                    bus_write(1, 1'b1, $urandom & 32'h0000_0E01);
                    check_status(1, $sformatf("rnd_wr_status%0d", it));
                end
                default: ;
            endcase
            idle(3);
            check($sformatf("rnd_irq%0d", it), {31'd0, irq1},
                  {31'd0, m_re[1] & (mq1.size() != 0)});
        end
        check_status(1, "rnd_final_status");
        for (int i = 0; i < 9; i++) check_data(1, $sformatf("drain%0d", i));

        // Reset in the middle of the payload
        b = 8'hC3;
        rxd0 = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd0 = b[i];
            if (i == 3) rst = 1'b1;
            idle(BIT_CYC);
        end
        rxd0 = 1'b1;
        idle(BIT_CYC);
        rst = 1'b0;
        model_reset();
        idle(3);
        check("midreset_rdata0", rdata0, 32'd0);
        check_status(0, "midreset_status0");
        send_frame(0, 8'h5A, 0, 0);
        check_data(0, "after_reset_5a");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
